// File: rtl/mem_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_arbiter_pkg
// Brief    : Shared constants and types for the memory request arbiter.
// Revision : 1.0
// ============================================================================
package mem_req_arbiter_pkg;

    localparam int OUTST_DEPTH_DEF = 2;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_LOCK = 1'b1;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_bundle_t;

endpackage
`default_nettype wire

// File: rtl/arb_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : arb_id_fifo
// Brief    : Synchronous 1-bit FIFO recording the source order of accepted requests.
// Revision : 1.0
// ============================================================================
module arb_id_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       i_push,
    input  logic                       i_push_id,
    input  logic                       i_pop,
    output logic                       o_head_id,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] r_mem;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head_id = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_push_id;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_arbiter
// Brief    : Arbitrates fetch and EXE sram-like requests onto one downstream port.
//            Define ARB_ROUND_ROBIN_EN for round-robin instead of data-first priority.
// Revision : 1.0
// ============================================================================
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int OUTST_DEPTH = OUTST_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic        r_lock_id;
    logic        w_pick_id;
    logic        w_sel_id;
    logic        w_grant;
    logic        w_push;
    logic        w_pop;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_head_id;
    logic [$clog2(OUTST_DEPTH+1)-1:0] w_fifo_count;
    logic        w_unused_count;
    req_bundle_t w_inst_b;
    req_bundle_t w_data_b;
    req_bundle_t w_sel_b;

    assign w_inst_b = '{wr: inst_wr, size: inst_size, addr: inst_addr,
                        wstrb: inst_wstrb, wdata: inst_wdata};
    assign w_data_b = '{wr: data_wr, size: data_size, addr: data_addr,
                        wstrb: data_wstrb, wdata: data_wdata};

`ifdef ARB_ROUND_ROBIN_EN
    logic r_prio;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_prio <= SRC_DATA;
        end else if (w_push) begin
            r_prio <= ~w_sel_id;
        end
    end

    assign w_pick_id = (inst_req && data_req) ? r_prio :
                       (data_req ? SRC_DATA : SRC_INST);
`else
    assign w_pick_id = data_req ? SRC_DATA : SRC_INST;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= ARB_IDLE;
            r_lock_id <= SRC_INST;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ARB_IDLE && w_grant && !mem_addr_ok) begin
                r_lock_id <= w_sel_id;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: if (w_grant && !mem_addr_ok) w_state_nxt = ARB_LOCK;
            ARB_LOCK: if (mem_addr_ok)             w_state_nxt = ARB_IDLE;
            default:                               w_state_nxt = ARB_IDLE;
        endcase
    end

    // Grant is masked while reset is asserted so nothing leaks onto mem_* early.
    always_comb begin
        w_grant  = 1'b0;
        w_sel_id = w_pick_id;
        case (r_state)
            ARB_IDLE: w_grant = !w_fifo_full && (inst_req || data_req);
            ARB_LOCK: begin
                w_grant  = 1'b1;
                w_sel_id = r_lock_id;
            end
            default:  w_grant = 1'b0;
        endcase
        if (!resetn) begin
            w_grant = 1'b0;
        end
    end

    assign w_push  = w_grant && mem_addr_ok;
    assign w_pop   = resetn && mem_data_ok && !w_fifo_empty;
    assign w_sel_b = (w_sel_id == SRC_DATA) ? w_data_b : w_inst_b;

    assign mem_req   = w_grant;
    assign mem_wr    = w_grant ? w_sel_b.wr    : 1'b0;
    assign mem_size  = w_grant ? w_sel_b.size  : 2'b00;
    assign mem_addr  = w_grant ? w_sel_b.addr  : 32'h0;
    assign mem_wstrb = w_grant ? w_sel_b.wstrb : 4'h0;
    assign mem_wdata = w_grant ? w_sel_b.wdata : 32'h0;

    assign inst_addr_ok = w_push && (w_sel_id == SRC_INST);
    assign data_addr_ok = w_push && (w_sel_id == SRC_DATA);
    assign inst_data_ok = w_pop && (w_head_id == SRC_INST);
    assign data_data_ok = w_pop && (w_head_id == SRC_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    arb_id_fifo #(
        .DEPTH (OUTST_DEPTH)
    ) u_id_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .i_push    (w_push),
        .i_push_id (w_sel_id),
        .i_pop     (w_pop),
        .o_head_id (w_head_id),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

    assign w_unused_count = &{1'b0, w_fifo_count};

endmodule
`default_nettype wire

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter OUTST_DEPTH, default 2: max accepted-but-unanswered requests; power of two, 2..8.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 resetn  in  1  reset, synchronous and active-low.
REQ-004 inst_req, inst_wr, inst_size[1:0], inst_addr[31:0], inst_wstrb[3:0], inst_wdata[31:0]  in  1/1/2/32/4/32  fetch-side sram-like request bundle.
REQ-005 inst_addr_ok, inst_data_ok  out  1/1  fetch-side request accept / response valid.
REQ-006 inst_rdata  out  32  fetch-side read data, valid with inst_data_ok.
REQ-007 data_req, data_wr, data_size[1:0], data_addr[31:0], data_wstrb[3:0], data_wdata[31:0]  in  1/1/2/32/4/32  EXE-side sram-like request bundle.
REQ-008 data_addr_ok, data_data_ok  out  1/1  EXE-side request accept / response valid.
REQ-009 data_rdata  out  32  EXE-side read data, valid with data_data_ok.
REQ-010 mem_req, mem_wr, mem_size[1:0], mem_addr[31:0], mem_wstrb[3:0], mem_wdata[31:0]  out  1/1/2/32/4/32  shared downstream request bundle.
REQ-011 mem_addr_ok, mem_data_ok  in  1/1  downstream accept / in-order response valid.
REQ-012 mem_rdata  in  32  downstream read data.

Function
REQ-013 Two-state grant FSM, states ARB_IDLE and ARB_LOCK, plus one source-ID order FIFO (1-bit entries, OUTST_DEPTH deep) and occupancy counter.
REQ-014 ARB_IDLE, FIFO not full, any req: winner chosen combinationally; winner bundle drives mem_* the same cycle, mem_req=1.
REQ-015 ARB_IDLE winner with mem_addr_ok=1: winner's addr_ok=1 same cycle, winner ID pushed, stay ARB_IDLE.
REQ-016 ARB_IDLE winner with mem_addr_ok=0: register winner ID, go ARB_LOCK.
REQ-017 ARB_LOCK: mem_* driven only from locked source regardless of other req; on mem_addr_ok, locked source addr_ok=1, push ID, return ARB_IDLE.
REQ-018 Requesters hold bundle stable until addr_ok; loser sees addr_ok=0 and no side effect.
REQ-019 FIFO full: mem_req=0, both addr_ok=0, FSM stays ARB_IDLE; a pop in the same cycle does not unblock a push (push waits one cycle).
REQ-020 mem_data_ok with FIFO non-empty: pop head; head ID 0 -> inst_data_ok=1, ID 1 -> data_data_ok=1; matching rdata = mem_rdata; zero added latency.
REQ-021 Both *_rdata outputs = mem_rdata combinationally; only data_ok qualifies them.
REQ-022 Push and pop same cycle (not full): both performed, occupancy unchanged.
REQ-023 mem_data_ok with FIFO empty: ignored, no data_ok asserted, state unchanged.
REQ-024 Downstream guarantees mem_data_ok no earlier than cycle after matching mem_addr_ok; same-cycle pass-through of a push is not supported.
REQ-025 Writes occupy a FIFO slot and receive data_ok like reads.

Reset
REQ-026 resetn=0 at posedge: FSM -> ARB_IDLE, FIFO pointers and occupancy -> 0, priority pointer -> data side.
REQ-027 During and after reset until first grant: mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok = 0; other mem_* = 0.
REQ-028 Reset mid-transaction discards locked grant and outstanding IDs; late mem_data_ok treated per REQ-023.

Configuration
REQ-029 Macro ARB_ROUND_ROBIN_EN defined: 1-bit priority pointer flips to other source after every accepted push; winner = pointer side when both req.
REQ-030 Macro undefined: fixed priority, data side always wins when both req; pointer logic absent.

Structure
REQ-031 Shared package holds source-ID constants (SRC_INST=0, SRC_DATA=1), FSM state encodings, OUTST_DEPTH default.
REQ-032 One sub-module: arb_id_fifo (synchronous FIFO with full/empty/count), instantiated once.

Verification
REQ-033 Both req same cycle, mem_addr_ok=1, fixed priority -> data_addr_ok=1 cycle 0, inst_addr_ok=1 cycle 1; data_data_ok before inst_data_ok.
REQ-034 inst_req alone, mem_addr_ok low 3 cycles, data_req rises cycle 1 -> FSM ARB_LOCK, mem_addr=inst_addr through cycle 3, inst_addr_ok at cycle 3 only.
REQ-035 OUTST_DEPTH=2, three back-to-back data reads, no data_ok -> third stalls with mem_req=0; mem_data_ok with rdata 0x1234_5678 -> data_data_ok, data_rdata=0x1234_5678, third accepted next cycle.
REQ-036 ARB_ROUND_ROBIN_EN, both req held 4 grants -> grant order data, inst, data, inst.
REQ-037 Spurious mem_data_ok at empty FIFO -> no data_ok; resetn=0 with 2 outstanding -> occupancy 0, outputs 0 next cycle.
